// File: rtl/dadda_pkg.sv
// Shared widths and response record for the shared 8x8 multiplier path.
// No logic; no latency; no backpressure.
package dadda_pkg;
    localparam int MUL_BIT   = 8;
    localparam int PROD_BIT  = 16;
    localparam int ID_MAX_W  = 4;

    // id is sized for the largest requester count; narrower builds zero-extend
    typedef struct packed {
        logic [PROD_BIT-1:0] data;
        logic [ID_MAX_W-1:0] id;
    } rsp_t;
endpackage

// File: rtl/DADDA_8x8.sv
// Combinational unsigned 8x8 -> 16 multiplier shared by all requesters.
// Zero latency; no backpressure (pure function of a and b).
module DADDA_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] out
);
    always_comb begin
        out = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                out = out + ({8'h00, a} << i);
            end
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N_REQ.
// Combinational; en=0 forces an all-zero grant while idx still tracks the winner.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
                gnt[j] = en;
            end
        end
    end
endmodule

// File: rtl/dadda_mul_arbiter.sv
// Round-robin sharing of one DADDA_8x8 between N_REQ valid/ready requesters.
// Latency 1 cycle grant->rsp_valid (2 with DADDA_ARB_PIPE_EN operand stage).
// Grants only when the next stage can take the product; rsp held while !rsp_ready.
module dadda_mul_arbiter
    import dadda_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [MUL_BIT*N_REQ-1:0] req_a,
    input  logic [MUL_BIT*N_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PROD_BIT-1:0]      rsp_data,
    output logic [ID_W-1:0]          rsp_id
);
    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     win;
    logic                grant;
    logic                slot_free;
    logic                rsp_free;
    logic                rsp_load;
    logic [MUL_BIT-1:0]  sel_a;
    logic [MUL_BIT-1:0]  sel_b;
    logic [MUL_BIT-1:0]  mul_a;
    logic [MUL_BIT-1:0]  mul_b;
    logic [ID_W-1:0]     load_id;
    logic [PROD_BIT-1:0] prod;
    rsp_t                rsp_q;
    logic                unused_id_bits;

    assign rsp_free = !rsp_valid || rsp_ready;
    assign sel_a    = req_a[int'(win)*MUL_BIT +: MUL_BIT];
    assign sel_b    = req_b[int'(win)*MUL_BIT +: MUL_BIT];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (slot_free && reset_n),
        .gnt (gnt),
        .idx (win)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
        end
    end

`ifdef DADDA_ARB_PIPE_EN
    logic               op_vld;
    logic [MUL_BIT-1:0] op_a;
    logic [MUL_BIT-1:0] op_b;
    logic [ID_W-1:0]    op_id;

    // operand stage frees up in the same cycle it hands off to the response register
    assign rsp_load  = op_vld && rsp_free;
    assign slot_free = !op_vld || rsp_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_vld <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
        end else if (grant) begin
            op_vld <= 1'b1;
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= win;
        end else if (rsp_load) begin
            op_vld <= 1'b0;
        end
    end

    assign mul_a   = op_a;
    assign mul_b   = op_b;
    assign load_id = op_id;
`else
    assign slot_free = rsp_free;
    assign rsp_load  = grant;
    assign mul_a     = sel_a;
    assign mul_b     = sel_b;
    assign load_id   = win;
`endif

    DADDA_8x8 u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .out (prod)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (rsp_load) begin
            rsp_valid  <= 1'b1;
            rsp_q.data <= prod;
            rsp_q.id   <= ID_MAX_W'(load_id);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_data       = rsp_q.data;
    assign rsp_id         = rsp_q.id[ID_W-1:0];
    assign unused_id_bits = ^rsp_q.id;
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Scoreboard bench for dadda_mul_arbiter: grant observer predicts round-robin winners
// and products, a separate response monitor pops and compares.
module tb_dadda_mul_arbiter;
    localparam int N = 4;
`ifdef DADDA_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clock;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [15:0]    rsp_data;
    logic [1:0]     rsp_id;

    dadda_mul_arbiter #(.N_REQ(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        logic [15:0] data;
        int          id;
        int          gcyc;
    } exp_t;

    exp_t         q[$];
    int           glog[$];
    int           gcyc_log[$];
    int           cyc = 0;
    int           mptr = 0;
    int           nchk = 0;
    int           nerr = 0;
    bit           head_seen = 0;
    bit           strict = 0;
    logic [N-1:0] gmask = '0;
    int           obs_w;
    bit           obs_found;
    int           pa, pb;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Grant observer: reference round-robin over the bench's own pointer.
    always @(negedge clock) begin
        gmask = '0;
        if (reset_n) begin
            obs_found = 0;
            obs_w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!obs_found && req_valid[(mptr + k) % N]) begin
                    obs_found = 1;
                    obs_w     = (mptr + k) % N;
                end
            end
            if (req_ready != '0) begin
                check("grant", 32'(req_ready), obs_found ? (32'd1 << obs_w) : 32'd0);
                if (obs_found && req_ready[obs_w]) begin
                    pa = int'(req_a[8*obs_w +: 8]);
                    pb = int'(req_b[8*obs_w +: 8]);
                    q.push_back('{data: 16'(pa * pb), id: obs_w, gcyc: cyc});
                    glog.push_back(obs_w);
                    gcyc_log.push_back(cyc);
                    mptr = (obs_w + 1) % N;
                    gmask[obs_w] = 1'b1;
                end
            end else if (obs_found) begin
`ifdef DADDA_ARB_PIPE_EN
                check("stall_rsp_ready", 32'(rsp_ready), 32'd0);
`else
                check("stall_slot_busy", 32'(rsp_valid && !rsp_ready), 32'd1);
`endif
            end
        end
    end

    // Response monitor
    always @(negedge clock) begin
        if (reset_n && rsp_valid) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1;
                    if (strict) check("latency", 32'(cyc - q[0].gcyc), 32'(LAT));
                    else        check("latency_min", 32'((cyc - q[0].gcyc) >= LAT), 32'd1);
                end
                if (rsp_ready) begin
                    check("rsp_data", 32'(rsp_data), 32'(q[0].data));
                    check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                    void'(q.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        req_valid = req_valid & ~gmask;
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = 1'b1;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        req_valid = '0;
        q.delete();
        glog.delete();
        gcyc_log.delete();
        mptr      = 0;
        head_seen = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_drained(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (req_valid == '0 && q.size() == 0 && !rsp_valid) return;
            step();
        end
        timeout(name);
    endtask

    task automatic wait_rsp(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) return;
            step();
        end
        timeout(name);
    endtask

    function automatic logic [7:0] rnd_op();
        int r;
        r = $urandom % 8;
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom);
    endfunction

    initial begin
        int issued;
        reset_n   = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset_n   = 1'b1;

        // single requester 2, 12*13
        strict = 1;
        step();
        issue(2, 8'd12, 8'd13);
        wait_drained("t1_drain", 20);
        check("t1_ngrant", 32'(glog.size()), 32'd1);
        if (glog.size() >= 1) check("t1_gid", 32'(glog[0]), 32'd2);

        // all four valid: 0,1,2,3 then wrap to 0
        do_reset();
        strict = 1;
        for (int i = 0; i < N; i++) issue(i, rnd_op(), rnd_op());
        for (int i = 0; i < 20 && req_valid != '0; i++) step();
        for (int i = 0; i < N; i++) issue(i, rnd_op(), rnd_op());
        wait_drained("t2_drain", 30);
        check("t2_ngrant", 32'(glog.size()), 32'd8);
        if (glog.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t2_order", 32'(glog[i]), 32'(i % N));
            for (int i = 1; i < 8; i++) check("t2_b2b", 32'(gcyc_log[i] - gcyc_log[i-1]), 32'd1);
        end

        // backpressure with 255*255 pending
        strict    = 0;
        rsp_ready = 1'b0;
        issue(0, 8'd255, 8'd255);
        wait_rsp("t3_rsp", 10);
        issue(1, 8'd3, 8'd5);
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_ready", 32'(req_ready), 32'd0);
            check("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check("t3_hold_data", 32'(rsp_data), 32'hFE01);
            step();
        end
        rsp_ready = 1'b1;
        wait_drained("t3_drain", 20);

        // ptr=2 with requesters 3 and 1
        do_reset();
        strict = 1;
        issue(1, 8'd7, 8'd9);
        wait_drained("t4_pre", 20);
        glog.delete();
        issue(3, rnd_op(), rnd_op());
        issue(1, rnd_op(), rnd_op());
        wait_drained("t4_drain", 20);
        check("t4_ngrant", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("t4_first", 32'(glog[0]), 32'd3);
            check("t4_second", 32'(glog[1]), 32'd1);
        end

        // async reset with a pending response
        do_reset();
        strict    = 0;
        rsp_ready = 1'b0;
        issue(2, 8'd100, 8'd200);
        wait_rsp("t5_rsp", 10);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        issue(0, 8'd17, 8'd19);
        issue(3, 8'd21, 8'd23);
        #1;
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_data", 32'(rsp_data), 32'd0);
        check("t5_rst_id", 32'(rsp_id), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        q.delete();
        glog.delete();
        gcyc_log.delete();
        mptr      = 0;
        head_seen = 0;
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        wait_drained("t5_drain", 20);
        check("t5_ngrant", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("t5_first", 32'(glog[0]), 32'd0);
            check("t5_second", 32'(glog[1]), 32'd3);
        end

        // random sweep of 100 operand pairs
        strict = 0;
        glog.delete();
        issued = 0;
        for (int c = 0; c < 4000 && issued < 100; c++) begin
            for (int i = 0; i < N; i++) begin
                if (issued < 100 && !req_valid[i] && ($urandom % 2) == 1) begin
                    issue(i, rnd_op(), rnd_op());
                    issued++;
                end
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        rsp_ready = 1'b1;
        wait_drained("t6_drain", 100);
        check("t6_ngrant", 32'(glog.size()), 32'd100);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
